// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the UART receive and transmit paths
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  function automatic logic uart_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_synchronizer.sv
// uart_synchronizer: multi-flop synchroniser for asynchronous inputs, resets to 1
module uart_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= reset ? '1 : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX pin sync, start-edge detect, oversample counter and 3-vote mid-bit sampling
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_clk_en,
  input  logic rx,
  input  logic rx_sample_cnt_reset,
  output logic rx_sync,
  output logic rx_sync_fall,
  output logic rx_get_sample,
  output logic rx_bit,
  output logic rx_noise
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] V0_AT = CW'(OVERSAMPLE / 2 - 3);
  localparam logic [CW-1:0] V1_AT = CW'(OVERSAMPLE / 2 - 2);
  logic [CW-1:0] cnt;
  logic rx_prev, v0, v1;
  uart_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_sync)
  );
  // the two ticks before mid-bit hold the first two votes; the third is live
  always_ff @(posedge clk)
    if (reset) begin
      cnt     <= '0;
      rx_prev <= 1'b1;
      v0      <= 1'b1;
      v1      <= 1'b1;
    end else begin
      cnt <= rx_sample_cnt_reset ? '0 : rx_clk_en ? cnt + 1'b1 : cnt;
      if (rx_clk_en) begin
        rx_prev <= rx_sync;
        if (cnt == V0_AT) v0 <= rx_sync;
        if (cnt == V1_AT) v1 <= rx_sync;
      end
    end
  assign rx_sync_fall  = rx_prev & ~rx_sync;
  assign rx_get_sample = rx_clk_en & (cnt == MID);
  assign rx_bit        = uart_maj3(v0, v1, rx_sync);
  assign rx_noise      = rx_get_sample & ~(v0 == v1 && v1 == rx_sync);
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Receive front end of the UART, directly upstream of `uart_rx_controller`. It does four things:
- synchronises the asynchronous RX pin into the `clk` domain;
- detects the start-bit falling edge on oversampling ticks;
- runs the per-bit oversample counter that produces the mid-bit `rx_get_sample` strobe;
- delivers a 3-sample majority-voted data bit and a noise flag to the controller and sample register.

## Interface

Parameters:
- `OVERSAMPLE`, 16: `rx_clk_en` ticks per bit. Power of two, ≥ 8.
- `SYNC_STAGES`, 2: flip-flop depth of the pin synchroniser, ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx_clk_en`  in  1  oversampling tick from the baud generator, one `clk` wide.
- `rx`  in  1  raw asynchronous RX pin; idle high.
- `rx_sample_cnt_reset`  in  1  from controller; clears the oversample counter.
- `rx_sync`  out  1  synchronised line level.
- `rx_sync_fall`  out  1  falling edge seen between the previous tick and now.
- `rx_get_sample`  out  1  mid-bit strobe, one `clk` wide, coincident with a tick.
- `rx_bit`  out  1  majority-voted bit value, valid while `rx_get_sample` = 1.
- `rx_noise`  out  1  the three votes disagreed, valid while `rx_get_sample` = 1.

## Operation

- **Synchroniser**
  - `SYNC_STAGES` flops shift `rx` on every `clk`, regardless of tick.
  - `rx_sync` is the last stage.
- **Edge detect**
  - `rx_prev` captures `rx_sync` on each tick.
  - `rx_sync_fall = rx_prev & ~rx_sync` (combinational).
  - The controller consumes it only on tick cycles.
- **Oversample counter** `cnt`, width log2(`OVERSAMPLE`):
  - Priority 1: `rx_sample_cnt_reset` = 1 on any cycle → `cnt` ← 0.
  - Priority 2: else on a tick → `cnt` ← `cnt`+1, wrapping `OVERSAMPLE`-1 → 0.
  - Otherwise it holds.
- **Strobe**
  - `MID = OVERSAMPLE/2 - 1`.
  - `rx_get_sample = rx_clk_en & (cnt == MID)`.
  - This is evaluated on the pre-increment `cnt`, and asserts even on a cycle where `rx_sample_cnt_reset` is also high. The controller ignores it in idle.
- **Voting**
  - On ticks with `cnt == MID-2` and `cnt == MID-1`, capture `rx_sync` into `v0` and `v1` respectively.
  - `rx_bit = maj(v0, v1, rx_sync)`.
  - `rx_noise = rx_get_sample & ~(v0 == v1 && v1 == rx_sync)`.
- **Free-running**
  - The counter keeps running after a frame ends.
  - The next start edge re-aligns it via the controller's `rx_sample_cnt_reset`.

## Timing

- **Reset values**
  - All synchroniser stages, `rx_prev`, `v0` and `v1` = 1.
  - `cnt` = 0.
  - Outputs: `rx_sync` = 1, `rx_sync_fall` = 0, `rx_get_sample` = 0, `rx_bit` = 1, `rx_noise` = 0.
  - Reset mid-frame returns all of these to reset values on the next edge; no strobe is issued on the reset cycle's outputs after the edge.
- **Pin latency**: a level change on `rx` appears on `rx_sync` exactly `SYNC_STAGES` `clk` edges later.
- **Start-edge alignment**
  - Let the fall be seen on tick T0; the controller clears `cnt` on that cycle.
  - The first `rx_get_sample` occurs on the (`MID`+1)-th tick after T0, i.e. tick 8 for `OVERSAMPLE` = 16, the start-bit centre.
  - Subsequent strobes follow exactly every `OVERSAMPLE` ticks.
- **Tick spacing**: no assumption on the `clk`-to-tick ratio; back-to-back ticks (`rx_clk_en` tied high) are legal.
- **Between ticks**: `cnt`, `rx_prev`, `v0` and `v1` hold, and `rx_get_sample` = 0.
- **Wrap-around**: `cnt` goes `OVERSAMPLE`-1 → 0 on a tick without any extra strobe.

## Structure

- **Shared package** `uart_pkg`: `UART_OVERSAMPLE` = 16 as the default for `OVERSAMPLE`, and a `uart_maj3` function. The TX side uses the same constant.
- **Sub-module** `uart_synchronizer`, parameter `STAGES`, reset value 1. It is a generic multi-flop synchroniser and is reused for CTS later.
- **Remainder**: edge detect, counter and voting stay in this module.

## Test plan

- **Reset**: assert `reset` mid-frame with `rx` = 0 → next cycle `rx_sync` = 1, `cnt` = 0, all strobes 0; `rx_sync` reaches 0 after 2 clocks once released.
- **Clean frame**
  - Stimulus: `OVERSAMPLE` = 16, tick every 4 clk, byte 0x55 at 1 bit per 64 clk, with a controller model pulsing `rx_sample_cnt_reset` on the fall tick.
  - Response: 10 strobes 64 clk apart, the first 8 ticks after the fall; `rx_bit` sequence 0,1,0,1,0,1,0,1,0,1; `rx_noise` = 0 throughout.
- **Glitch vote**: 1-tick low pulse on a high data bit at `cnt` = `MID`-1 → `rx_bit` = 1 and `rx_noise` = 1 on that strobe.
- **Synchroniser latency**: toggle `rx` with `rx_clk_en` = 0 → `rx_sync` follows 2 clk later; `rx_sync_fall` stays 1 until the next tick, then 0.
- **Simultaneous events**: `rx_sample_cnt_reset` held on a tick with `cnt` = `MID` → `rx_get_sample` = 1 that cycle and `cnt` = 0 afterwards.
- **Wrap and continuous ticks**: `rx_clk_en` tied high with no counter reset for 40 cycles → strobes at cycles 7, 23 and 39 only.
